exp_engine_wrapper: RTL and testbench

Parametrised fixed-point exponential engine with start/done handshake and a flow-controlled write port. Computes e^x or e^-x for an unsigned fractional input by Taylor series, one term per clock, then writes a tagged result to a downstream FIFO. It is the next generation of the lab's single-width wrapper, adding:
- generic width and term count
- a sign mode
- FIFO backpressure
- a busy indication

---
 rtl/exp_pkg.sv | 21 ++
 rtl/exp_recip_rom.sv | 19 +
 rtl/exp_engine_wrapper.sv | 137 +++++++++++++
 tb/tb_exp_engine_wrapper.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared types, defaults and constant helpers for the Taylor-series exponential engine.
package exp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned UW_DEF    = 2;
    localparam int unsigned TERMS_DEF = 8;
    localparam int unsigned KW        = 5;   // holds k up to 16
    localparam logic [31:0] ONE       = 32'd1 << DW_DEF;

    function automatic int unsigned recip(input int unsigned k, input int unsigned dw);
        return (k == 0) ? 0 : ((32'd1 << dw) / k);
    endfunction

endpackage

// File: rtl/exp_recip_rom.sv
// Combinational k -> floor(2^DW/k) table for the Taylor term divisor; k < 2 returns 0.
module exp_recip_rom
    import exp_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TERMS = TERMS_DEF
) (
    input  logic [KW-1:0] k_i,
    output logic [DW-1:0] r_o
);

    always_comb begin
        r_o = '0;
        for (int unsigned i = 2; i < TERMS; i++) begin
            if (k_i == KW'(i)) r_o = DW'(recip(i, DW));
        end
    end

endmodule

// File: rtl/exp_engine_wrapper.sv
// Fixed-point e^x / e^-x engine: one Taylor term per clock, tagged result written
// to a flow-controlled FIFO port.
//
//   state | meaning
//   IDLE  | waiting for w_start; operands latched on accept
//   CALC  | accumulate term k, k = 1 .. TERMS-1
//   WRITE | wr_req held with stable wr_data until !wr_full
//   DONE  | one-cycle w_done pulse
module exp_engine_wrapper
    import exp_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned UW    = UW_DEF,
    parameter int unsigned TERMS = TERMS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_start,
    input  logic              mode,
    input  logic [UW-1:0]     Ui,
    input  logic [DW-1:0]     x,
    input  logic              wr_full,
    output logic              busy,
    output logic              w_done,
    output logic              wr_req,
    output logic [UW+DW+1:0]  wr_data
);

    localparam int unsigned AW = DW + 2;
    localparam int unsigned PW = 2 * DW + 2;
    localparam logic [AW-1:0] ONE_L  = AW'(1) << DW;
    localparam logic [KW-1:0] K_LAST = KW'(TERMS - 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AW-1:0]       term_q, term_d;
    logic [KW-1:0]       k_q, k_d;
    logic [DW-1:0]       x_q, x_d;
    logic [UW-1:0]       tag_q, tag_d;
    logic                mode_q, mode_d;
    logic [UW+DW+1:0]    data_q, data_d;

    logic [DW-1:0]       r_k;
    logic [AW-1:0]       scaled, t_mul, t, acc_next;
    logic [AW:0]         sum;

    exp_recip_rom #(.DW(DW), .TERMS(TERMS)) u_rom (
        .k_i (k_q),
        .r_o (r_k)
    );

    // Each product is truncated back to 2.DW before the next multiply.
    assign scaled = AW'((PW'(term_q) * PW'(x_q)) >> DW);
    assign t_mul  = AW'((PW'(scaled) * PW'(r_k)) >> DW);
    assign t      = (k_q == KW'(1)) ? AW'(x_q) : t_mul;

    always_comb begin
        if (mode_q && k_q[0]) begin
            sum      = {1'b0, acc_q} - {1'b0, t};
            acc_next = sum[AW] ? '0 : sum[AW-1:0];
        end else begin
            sum      = {1'b0, acc_q} + {1'b0, t};
            acc_next = sum[AW] ? '1 : sum[AW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        term_d  = term_q;
        k_d     = k_q;
        x_d     = x_q;
        tag_d   = tag_q;
        mode_d  = mode_q;
        data_d  = data_q;
        busy    = 1'b1;
        w_done  = 1'b0;
        wr_req  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (w_start) begin
                    x_d     = x;
                    tag_d   = Ui;
                    mode_d  = mode;
                    acc_d   = ONE_L;
                    term_d  = ONE_L;
                    k_d     = KW'(1);
                    state_d = CALC;
                end
            end
            CALC: begin
                term_d = t;
                acc_d  = acc_next;
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    data_d  = {tag_q, acc_next};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_req = 1'b1;
                if (!wr_full) state_d = DONE;
            end
            DONE: begin
                w_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            term_q  <= '0;
            k_q     <= '0;
            x_q     <= '0;
            tag_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            term_q  <= term_d;
            k_q     <= k_d;
            x_q     <= x_d;
            tag_q   <= tag_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign wr_data = data_q;

endmodule

// File: tb/tb_exp_engine_wrapper.sv
// Directed, table-driven bench for exp_engine_wrapper (TERMS=8 main instance, TERMS=4 latency instance).
module tb_exp_engine_wrapper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, w_start, mode, wr_full;
    logic [1:0]  Ui;
    logic [15:0] x;
    logic        busy, w_done, wr_req;
    logic [19:0] wr_data;

    logic        w_start4, mode4, wr_full4;
    logic [1:0]  Ui4;
    logic [15:0] x4;
    logic        busy4, w_done4, wr_req4;
    logic [19:0] wr_data4;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int dones  = 0;

    exp_engine_wrapper #(.DW(16), .UW(2), .TERMS(8)) dut (
        .clk(clk), .rst(rst), .w_start(w_start), .mode(mode), .Ui(Ui), .x(x),
        .wr_full(wr_full), .busy(busy), .w_done(w_done), .wr_req(wr_req), .wr_data(wr_data)
    );

    exp_engine_wrapper #(.DW(16), .UW(2), .TERMS(4)) dut4 (
        .clk(clk), .rst(rst), .w_start(w_start4), .mode(mode4), .Ui(Ui4), .x(x4),
        .wr_full(wr_full4), .busy(busy4), .w_done(w_done4), .wr_req(wr_req4), .wr_data(wr_data4)
    );

    always @(posedge clk) begin
        if (rst && wr_req && !wr_full) xfers <= xfers + 1;
        if (rst && w_done) dones <= dones + 1;
    end

    typedef struct {
        logic [15:0] x;
        logic        m;
        logic [1:0]  tag;
        int          full_n;
        logic        pulse;
        logic [17:0] exp_res;
        int          tol;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic chk_tol(input string nm, input longint act, input longint req, input longint tol);
        longint d;
        d = act - req;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h +-%0d", nm, act, req, tol);
        end
    endtask

    task automatic run_op(input vec_t v, output logic [19:0] data, output int lat, output int dlat,
                          output int bcnt, output int unstable, output int nx, output int nd,
                          output logic idle_ok);
        int x0, d0;
        x0 = xfers; d0 = dones;
        bcnt = 0; unstable = 0; lat = 0; dlat = 0;
        @(negedge clk);
        w_start = 1'b1; x = v.x; mode = v.m; Ui = v.tag; wr_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        w_start = 1'b0;
        x = 16'($urandom); mode = 1'($urandom); Ui = 2'($urandom);
        while (!wr_req && lat < 40) begin
            if (busy) bcnt++;
            w_start = v.pulse && (lat == 3);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        w_start = 1'b0;
        data = wr_data;
        if (v.full_n > 0) wr_full = 1'b1;
        for (int i = 0; i < v.full_n; i++) begin
            if (busy) bcnt++;
            @(posedge clk);
            dlat++;
            @(negedge clk);
            if (!wr_req || wr_data !== data) unstable++;
        end
        wr_full = 1'b0;
        while (!w_done && dlat < 80) begin
            if (busy) bcnt++;
            @(posedge clk);
            dlat++;
            @(negedge clk);
        end
        if (busy) bcnt++;
        w_start = v.pulse;
        @(posedge clk);
        @(negedge clk);
        w_start = 1'b0;
        idle_ok = !busy && !wr_req && !w_done;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (busy || wr_req) idle_ok = 1'b0;
        end
        nx = xfers - x0;
        nd = dones - d0;
    endtask

    task automatic abort_seq();
        int x0, d0;
        logic seen;
        x0 = xfers; d0 = dones; seen = 1'b0;
        @(negedge clk);
        w_start = 1'b1; x = 16'h1234; mode = 1'b0; Ui = 2'b01;
        @(posedge clk);
        @(negedge clk);
        w_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wr_req", wr_req, 0);
        chk("abort_wr_data", wr_data, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wr_req || w_done || busy) seen = 1'b1;
        end
        chk("abort_activity", seen, 0);
        chk("abort_xfers", xfers - x0, 0);
        chk("abort_dones", dones - d0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] data;
        int          lat, dlat, bcnt, unstable, nx, nd;
        logic        idle_ok;

        //            x         m     tag    full pulse result     tol
        vecs[0] = '{16'h0000, 1'b0, 2'b00, 0, 1'b0, 18'h10000, 0};
        vecs[1] = '{16'h0000, 1'b1, 2'b10, 0, 1'b0, 18'h10000, 0};
        vecs[2] = '{16'hFFFF, 1'b0, 2'b01, 0, 1'b0, 18'h2B7DD, 8};
        vecs[3] = '{16'h8000, 1'b1, 2'b11, 0, 1'b0, 18'h09B46, 8};
        vecs[4] = '{16'h4000, 1'b0, 2'b10, 5, 1'b0, 18'h148B5, 8};
        vecs[5] = '{16'h8000, 1'b0, 2'b01, 0, 1'b1, 18'h1A612, 8};
        vecs[6] = '{16'h4000, 1'b0, 2'b00, 0, 1'b0, 18'h148B5, 8};

        rst = 1'b0;
        w_start = 1'b0; mode = 1'b0; Ui = 2'b00; x = 16'h0; wr_full = 1'b0;
        w_start4 = 1'b0; mode4 = 1'b0; Ui4 = 2'b00; x4 = 16'h0; wr_full4 = 1'b0;

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            w_start = 1'($urandom); mode = 1'($urandom); Ui = 2'($urandom);
            x = 16'($urandom); wr_full = 1'($urandom);
            w_start4 = 1'($urandom); x4 = 16'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d_outs", c), {busy, w_done, wr_req}, 0);
            chk($sformatf("rst%0d_wr_data", c), wr_data, 0);
            chk($sformatf("rst%0d_outs4", c), {busy4, w_done4, wr_req4, wr_data4}, 0);
        end
        @(negedge clk);
        w_start = 1'b0; wr_full = 1'b0; w_start4 = 1'b0; wr_full4 = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i == NV - 1) abort_seq();
            run_op(vecs[i], data, lat, dlat, bcnt, unstable, nx, nd, idle_ok);
            chk_tol($sformatf("v%0d_result", i), data[17:0], vecs[i].exp_res, vecs[i].tol);
            chk($sformatf("v%0d_tag", i), data[19:18], vecs[i].tag);
            chk($sformatf("v%0d_latency", i), lat, 7);
            chk($sformatf("v%0d_done_delay", i), dlat, 1 + vecs[i].full_n);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 9 + vecs[i].full_n);
            chk($sformatf("v%0d_stable", i), unstable, 0);
            chk($sformatf("v%0d_transfers", i), nx, 1);
            chk($sformatf("v%0d_done_pulses", i), nd, 1);
            chk($sformatf("v%0d_idle_after", i), idle_ok, 1);
        end

        // TERMS=4: three CALC cycles, so wr_req appears 3 cycles after the accept edge.
        @(negedge clk);
        w_start4 = 1'b1; x4 = 16'h4000; mode4 = 1'b0; Ui4 = 2'b10;
        @(posedge clk);
        @(negedge clk);
        w_start4 = 1'b0; x4 = 16'h0;
        lat = 0;
        while (!wr_req4 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("t4_latency", lat, 3);
        chk_tol("t4_result", wr_data4[17:0], 18'h148AA, 8);
        chk("t4_tag", wr_data4[19:18], 2'b10);
        dlat = 0;
        while (!w_done4 && dlat < 40) begin
            @(posedge clk);
            dlat++;
            @(negedge clk);
        end
        chk("t4_done_delay", dlat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
